// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between the execute stage (0)
// and the address/branch helper (1), with a one-entry result buffer per requester.
module alu_arbiter #(
  parameter int DW  = 32,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  output logic           resp0_valid,
  input  logic           resp0_ready,
  output logic [DW-1:0]  resp0_data,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic           resp1_valid,
  input  logic           resp1_ready,
  output logic [DW-1:0]  resp1_data,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_d1,
  output logic [DW-1:0]  alu_d2,
  input  logic [DW-1:0]  alu_dout,
  output logic           busy
);
  // Handshake: a request transfers in any cycle where reqN_valid && reqN_ready;
  // a result transfers in any cycle where respN_valid && respN_ready. The
  // requester holds op/a/b stable while valid && !ready; respN_data is held
  // stable by the buffer while valid && !ready.

  localparam logic [OPW-1:0] OP_ADD = '0;

  logic          inflight_v;
  logic          inflight_id;
  logic          last_grant;
  logic          buf0_v;
  logic          buf1_v;
  logic [DW-1:0] buf0_d;
  logic [DW-1:0] buf1_d;
  logic          elig0;
  logic          elig1;
  logic          grant0;
  logic          grant1;

  // A requester is blocked while its own op is in flight, and needs a buffer
  // that is empty or being drained this cycle so the capture two edges later fits.
  always_comb begin
    elig0  = req0_valid && !(inflight_v && !inflight_id) && (!buf0_v || resp0_ready);
    elig1  = req1_valid && !(inflight_v &&  inflight_id) && (!buf1_v || resp1_ready);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (elig0 && elig1) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  always_comb begin
    alu_op = OP_ADD;
    alu_d1 = '0;
    alu_d2 = '0;
    if (grant0) begin
      alu_op = req0_op;
      alu_d1 = req0_a;
      alu_d2 = req0_b;
    end else if (grant1) begin
      alu_op = req1_op;
      alu_d1 = req1_a;
      alu_d2 = req1_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_v  <= 1'b0;
      inflight_id <= 1'b0;
      last_grant  <= 1'b1;
      buf0_v      <= 1'b0;
      buf1_v      <= 1'b0;
      buf0_d      <= '0;
      buf1_d      <= '0;
    end else begin
      inflight_v <= grant0 || grant1;
      if (grant0 || grant1) begin
        inflight_id <= grant1;
        last_grant  <= grant1;
      end
      // Capture takes priority over a same-cycle pop of the same buffer.
      if (inflight_v && !inflight_id) begin
        buf0_v <= 1'b1;
        buf0_d <= alu_dout;
      end else if (buf0_v && resp0_ready) begin
        buf0_v <= 1'b0;
      end
      if (inflight_v && inflight_id) begin
        buf1_v <= 1'b1;
        buf1_d <= alu_dout;
      end else if (buf1_v && resp1_ready) begin
        buf1_v <= 1'b0;
      end
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign resp0_valid = buf0_v;
  assign resp1_valid = buf1_v;
  assign resp0_data  = buf0_d;
  assign resp1_data  = buf1_d;
  assign busy        = inflight_v || buf0_v || buf1_v;

endmodule
